dnn_layer_sequencer: RTL and testbench
======================================

DNN_LAYER_SEQUENCER -- requirements
Module: dnn_layer_sequencer

Interface
REQ-001 SHALL have parameter ROW_NUM, default 8, meaning input grid rows per frame (>=2).
REQ-002 SHALL have parameter OUT_NUM, default 8, meaning result beats per frame (>=2).
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 Port clk, input, 1 bit: sole clock, rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-006 Port en, input, 1 bit: global advance enable; 0 freezes all state.
REQ-007 Port input_grid_iv, input, 1 bit: one input row valid this cycle.
REQ-008 Port grid_we, output, 1 bit: write strobe to the grid buffer.
REQ-009 Port grid_row_addr, output, $clog2(ROW_NUM) bits: grid buffer row address.
REQ-010 Port layer_start, output, 1 bit: one-cycle start pulse to the compute engine.
REQ-011 Port layer_id, output, 3 bits: active layer code.
REQ-012 Port layer_done, input, 1 bit: engine completion level, held until sampled with en=1.
REQ-013 Port buf_sel, output, 1 bit: ping-pong activation buffer selecting the source.
REQ-014 Port result_iv, input, 1 bit: one result beat valid in OUTPUT.
REQ-015 Port busy, output, 1 bit: high in every state except IDLE.
REQ-016 Port frame_done, output, 1 bit: one-cycle pulse on the final result beat.
REQ-017 Port err, output, 2 bits: sticky errors; [0] unexpected layer_done, [1] dropped input row.

Function
REQ-018 States and codes: IDLE=0, INPUT_GRID=1, CONV_1=2, CONV_2=3, CONV_3=4, CLASSIFY_1=5, CLASSIFY_2=6, OUTPUT=7; compute states are 2..6.
REQ-019 No event SHALL be acted on in a cycle with en=0: no state, counter or buf_sel change, and grid_we=0, layer_start=0, frame_done=0.
REQ-020 IDLE, en&input_grid_iv: grid_we=1, grid_row_addr=0 combinationally; next state INPUT_GRID with row count 1.
REQ-021 INPUT_GRID, en&input_grid_iv: grid_we=1, grid_row_addr=row count, then increment.
REQ-022 Writing row ROW_NUM-1 SHALL move the FSM to CONV_1 and clear the row count; rows with input_grid_iv=0 are waited for indefinitely.
REQ-023 A start-pending flag SHALL set on entry to each compute state.
REQ-024 layer_start SHALL equal start-pending AND en; start-pending clears when layer_start is issued, giving exactly one pulse per compute state.
REQ-025 layer_id SHALL equal the state code in compute states, and 0 otherwise.
REQ-026 In a compute state, layer_done is accepted only when en=1 and start-pending=0.
REQ-027 An accepted layer_done SHALL toggle buf_sel and advance to the next code; CLASSIFY_2 advances to OUTPUT.
REQ-028 layer_done=1 in any non-compute state, or in a cycle where layer_start=1, SHALL set err[0] and otherwise be ignored.
REQ-029 input_grid_iv=1 with en=1 in states 2..7 SHALL set err[1]; the row is dropped and grid_we stays 0.
REQ-030 OUTPUT: each en&result_iv increments the beat count; the beat with count OUT_NUM-1 SHALL assert frame_done that cycle.
REQ-031 On that final beat the FSM SHALL return to IDLE next cycle, clearing the beat count and setting buf_sel=0; result_iv outside OUTPUT is ignored.
REQ-032 err bits SHALL remain set until rst; errors never stall the FSM.
REQ-033 Minimum frame latency: ROW_NUM input cycles + 2 cycles per compute layer + OUT_NUM cycles.

Reset
REQ-034 While rst=1 (asynchronous), the FSM SHALL be IDLE and all counters 0; outputs SHALL be grid_we=0, grid_row_addr=0, layer_start=0, layer_id=0, buf_sel=0, busy=0, frame_done=0, err=0.
REQ-035 rst mid-frame SHALL abort immediately with no pending start, and the first row after release SHALL write address 0.

Verification
REQ-036 Nominal frame: 8 rows back-to-back, layer_done 3 cycles after each start, 8 result beats -> grid_row_addr 0..7; layer_id 2,3,4,5,6; buf_sel 0,1,0,1,0,1; a single frame_done; then IDLE.
REQ-037 en toggled 0/1 every cycle throughout the nominal frame -> identical write, layer and buf_sel sequence; no action in any en=0 cycle.
REQ-038 layer_done=1 in IDLE, plus input_grid_iv=1 during CONV_2 -> err=2'b11; the frame still completes normally.
REQ-039 layer_done held high from entry to CONV_1 -> start on the first cycle, done accepted on the second, CONV_2 entered on the third; err[0]=1.
REQ-040 rst asserted in CLASSIFY_1 with buf_sel=1 -> same-cycle busy=0, buf_sel=0, layer_id=0; a fresh frame after release starts at row 0.
REQ-041 ROW_NUM=2, OUT_NUM=2 build -> the CONV_1 transition occurs after 2 rows and frame_done on the 2nd beat.

Source files
------------

// File: rtl/dnn_layer_sequencer.sv
// dnn_layer_sequencer: loads an input grid row by row, steps a compute engine through five layers,
// ping-pongs the activation buffer and collects result beats for one frame.
module dnn_layer_sequencer #(
    parameter int ROW_NUM = 8,
    parameter int OUT_NUM = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       input_grid_iv,
    output logic                       grid_we,
    output logic [$clog2(ROW_NUM)-1:0] grid_row_addr,
    output logic                       layer_start,
    output logic [2:0]                 layer_id,
    input  logic                       layer_done,
    output logic                       buf_sel,
    input  logic                       result_iv,
    output logic                       busy,
    output logic                       frame_done,
    output logic [1:0]                 err
);
    localparam int RW = $clog2(ROW_NUM);
    localparam int BW = $clog2(OUT_NUM);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        INPUT_GRID = 3'd1,
        CONV_1     = 3'd2,
        CONV_2     = 3'd3,
        CONV_3     = 3'd4,
        CLASSIFY_1 = 3'd5,
        CLASSIFY_2 = 3'd6,
        OUTPUT     = 3'd7
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [BW-1:0] beat_q, beat_d;
    logic          pend_q, pend_d;
    logic          buf_q, buf_d;
    logic [1:0]    err_q, err_d;
    logic          compute, loading;

    always_comb begin
        compute       = state_q >= CONV_1 && state_q <= CLASSIFY_2;
        loading       = state_q == IDLE || state_q == INPUT_GRID;
        grid_we       = !rst && en && input_grid_iv && loading;
        grid_row_addr = state_q == INPUT_GRID ? row_q : '0;
        layer_start   = pend_q && en;
        layer_id      = compute ? state_q : 3'd0;
        busy          = state_q != IDLE;
        frame_done    = en && result_iv && state_q == OUTPUT && beat_q == BW'(OUT_NUM - 1);
        buf_sel       = buf_q;
        err           = err_q;
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        beat_d  = beat_q;
        pend_d  = pend_q;
        buf_d   = buf_q;
        err_d   = err_q;
        if (en) begin
            // a done seen while the start is still outstanding cannot belong to this layer
            if (layer_done && (!compute || pend_q)) err_d[0] = 1'b1;
            if (input_grid_iv && !loading) err_d[1] = 1'b1;
            if (state_q == IDLE) begin
                if (input_grid_iv) begin
                    state_d = INPUT_GRID;
                    row_d   = RW'(1);
                end
            end else if (state_q == INPUT_GRID) begin
                if (input_grid_iv) begin
                    state_d = row_q == RW'(ROW_NUM - 1) ? CONV_1 : INPUT_GRID;
                    row_d   = row_q == RW'(ROW_NUM - 1) ? '0 : row_q + RW'(1);
                    pend_d  = row_q == RW'(ROW_NUM - 1);
                end
            end else if (compute) begin
                if (pend_q) begin
                    pend_d = 1'b0;
                end else if (layer_done) begin
                    buf_d   = !buf_q;
                    state_d = state_q == CLASSIFY_2 ? OUTPUT : state_t'(state_q + 3'd1);
                    pend_d  = state_q != CLASSIFY_2;
                end
            end else if (result_iv) begin
                state_d = beat_q == BW'(OUT_NUM - 1) ? IDLE : OUTPUT;
                beat_d  = beat_q == BW'(OUT_NUM - 1) ? '0 : beat_q + BW'(1);
                buf_d   = beat_q == BW'(OUT_NUM - 1) ? 1'b0 : buf_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            beat_q  <= '0;
            pend_q  <= 1'b0;
            buf_q   <= 1'b0;
            err_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            beat_q  <= beat_d;
            pend_q  <= pend_d;
            buf_q   <= buf_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_dnn_layer_sequencer.sv
// tb_dnn_layer_sequencer: random and directed frames checked cycle by cycle against a
// frame-phase reference model; a second 2-row/2-beat instance covers the minimum build.
module tb_dnn_layer_sequencer;
    localparam int RN = 8, ON = 8;

    logic clk = 1'b0;
    logic rst, en, iv, done, rv;
    logic grid_we, layer_start, buf_sel, busy, frame_done;
    logic [2:0] grid_row_addr, layer_id;
    logic [1:0] err;
    logic en2, iv2, done2, rv2;
    logic grid_we2, layer_start2, buf_sel2, busy2, frame_done2;
    logic [0:0] grid_row_addr2;
    logic [2:0] layer_id2;
    logic [1:0] err2;

    dnn_layer_sequencer #(.ROW_NUM(RN), .OUT_NUM(ON)) dut (
        .clk(clk), .rst(rst), .en(en), .input_grid_iv(iv), .grid_we(grid_we),
        .grid_row_addr(grid_row_addr), .layer_start(layer_start), .layer_id(layer_id),
        .layer_done(done), .buf_sel(buf_sel), .result_iv(rv), .busy(busy),
        .frame_done(frame_done), .err(err));

    dnn_layer_sequencer #(.ROW_NUM(2), .OUT_NUM(2)) dut2 (
        .clk(clk), .rst(rst), .en(en2), .input_grid_iv(iv2), .grid_we(grid_we2),
        .grid_row_addr(grid_row_addr2), .layer_start(layer_start2), .layer_id(layer_id2),
        .layer_done(done2), .buf_sel(buf_sel2), .result_iv(rv2), .busy(busy2),
        .frame_done(frame_done2), .err(err2));

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    // phase: 0 idle, 1 loading rows, 2..6 layer code, 7 collecting results
    int phase, rows, beats, frames = 0, eng;
    logic bufm, pend, tog = 1'b0;
    logic [1:0] errm;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1; en = 1; iv = 1; done = 1; rv = 1;
        en2 = 0; iv2 = 0; done2 = 0; rv2 = 0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_buf_sel", buf_sel, 0);
        chk("rst_layer_id", layer_id, 0);
        chk("rst_grid_we", grid_we, 0);
        chk("rst_row_addr", grid_row_addr, 0);
        chk("rst_layer_start", layer_start, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        rst = 0; en = 0; iv = 0; done = 0; rv = 0;
        phase = 0; rows = 0; beats = 0; bufm = 0; pend = 0; eng = -1; errm = 0;
    endtask

    task automatic step();
        bit comp;
        comp = phase >= 2 && phase <= 6;
        #1;
        chk("busy", busy, phase != 0);
        chk("layer_id", layer_id, comp ? phase : 0);
        chk("buf_sel", buf_sel, bufm);
        chk("grid_we", grid_we, en && iv && phase <= 1);
        if (en && iv && phase <= 1) chk("row_addr", grid_row_addr, phase == 1 ? rows : 0);
        chk("layer_start", layer_start, en && comp && pend);
        chk("frame_done", frame_done, en && rv && phase == 7 && beats == ON - 1);
        chk("err", err, errm);
        if (eng > 0) eng--;
        if (en) begin
            if (done && (!comp || pend)) errm[0] = 1;
            if (iv && phase >= 2) errm[1] = 1;
            if (phase == 0) begin
                if (iv) begin phase = 1; rows = 1; end
            end else if (phase == 1) begin
                if (iv) begin
                    if (rows == RN - 1) begin phase = 2; rows = 0; pend = 1; end
                    else rows++;
                end
            end else if (comp) begin
                if (pend) begin pend = 0; eng = $urandom_range(1, 4); end
                else if (done) begin bufm = ~bufm; phase++; pend = phase <= 6; eng = -1; end
            end else if (rv) begin
                if (beats == ON - 1) begin phase = 0; beats = 0; bufm = 0; frames++; end
                else beats++;
            end
        end
        @(negedge clk);
    endtask

    // mode 0: random enable, 1: enable toggling every cycle, 2: enable always high
    task automatic rcycle(input int mode, input bit inj);
        en = mode == 2 ? 1'b1 : mode == 1 ? tog : ($urandom % 4 != 0);
        tog = ~tog;
        iv = phase <= 1 ? ($urandom % 3 != 0) : (inj && $urandom % 12 == 0);
        rv = phase == 7 ? 1'($urandom % 2) : ($urandom % 8 == 0);
        done = (phase >= 2 && phase <= 6 && eng == 0) ||
               (inj && (phase <= 1 || phase == 7) && $urandom % 12 == 0);
        step();
    endtask

    task automatic run_frames(input int n, input int mode, input bit inj);
        int target;
        target = frames + n;
        for (int c = 0; c < 400 * n && frames < target; c++) rcycle(mode, inj);
        chk("frame_count", frames, target);
    endtask

    task automatic feed_rows();
        en = 1; iv = 1; done = 0; rv = 0;
        for (int r = 0; r < RN; r++) step();
        iv = 0;
    endtask

    initial begin
        do_reset();
        run_frames(2, 2, 0);
        run_frames(2, 1, 0);
        run_frames(4, 0, 0);
        chk("err_clean", err, 0);
        run_frames(4, 0, 1);

        // layer_done held high from CONV_1 entry
        do_reset();
        feed_rows();
        done = 1;
        step();
        step();
        #1 chk("conv2_entry", layer_id, 3);
        step();
        chk("done_early_err", err, 2'b01);
        for (int c = 0; c < 20 && phase != 5; c++) begin
            done = phase >= 2 && phase <= 6 && !pend;
            step();
        end
        done = 0;
        #1 chk("cls1_buf", buf_sel, 1);
        chk("cls1_id", layer_id, 5);
        do_reset();
        en = 1; iv = 1;
        step();
        iv = 0;
        run_frames(1, 2, 0);

        // done in IDLE plus a row during CONV_2
        do_reset();
        en = 1; done = 1;
        step();
        feed_rows();
        for (int c = 0; c < 20 && !(phase == 3 && pend); c++) begin
            done = phase >= 2 && phase <= 6 && !pend;
            step();
        end
        done = 0; iv = 1;
        step();
        iv = 0;
        run_frames(1, 2, 0);
        chk("err_both", err, 2'b11);

        // two-row, two-beat instance
        do_reset();
        en2 = 1; iv2 = 1;
        for (int r = 0; r < 2; r++) begin
            #1 chk("m_we", grid_we2, 1);
            chk("m_addr", grid_row_addr2, r);
            @(negedge clk);
        end
        iv2 = 0;
        #1 chk("m_start", layer_start2, 1);
        chk("m_id", layer_id2, 2);
        @(negedge clk);
        for (int l = 2; l <= 6; l++) begin
            done2 = 1;
            #1 chk("m_id_done", layer_id2, l);
            chk("m_nostart", layer_start2, 0);
            @(negedge clk);
            done2 = 0;
            if (l < 6) begin
                #1 chk("m_next_start", layer_start2, 1);
                chk("m_next_id", layer_id2, l + 1);
                @(negedge clk);
            end
        end
        rv2 = 1;
        #1 chk("m_fd_beat1", frame_done2, 0);
        chk("m_busy_out", busy2, 1);
        @(negedge clk);
        #1 chk("m_fd_beat2", frame_done2, 1);
        @(negedge clk);
        rv2 = 0;
        #1 chk("m_idle", busy2, 0);
        chk("m_buf", buf_sel2, 0);
        chk("m_err", err2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
